// File: rtl/csel_addsub_pipe.sv
// Pipelined carry-select adder/subtractor with a global-stall valid/ready handshake.
// Each pipeline stage resolves BLK_PER_STG carry-select blocks. The last stage register drives the outputs.
module csel_addsub_pipe #(
    parameter int WIDTH       = 32,
    parameter int BLOCK       = 4,
    parameter int BLK_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NBLK    = WIDTH / BLOCK;
    localparam int STG_RAW = (NBLK + BLK_PER_STG - 1) / BLK_PER_STG;
    localparam int STAGES  = (STG_RAW < 1) ? 1 : STG_RAW;

    // Ripple one block; the result is {carry_out, sum_bits}.
    function automatic logic [BLOCK:0] rip(input logic [BLOCK-1:0] x,
                                           input logic [BLOCK-1:0] y,
                                           input logic             c);
        logic             cc;
        logic [BLOCK-1:0] s;
        cc = c;
        s  = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        return {cc, s};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];
    logic             c_p   [STAGES];
    logic             ovf_p [STAGES];
    logic             vld_p [STAGES];

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;

    assign adv      = !vld_p[STAGES-1] || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int LO = s * BLK_PER_STG;
        localparam int HI = ((s + 1) * BLK_PER_STG < NBLK) ? (s + 1) * BLK_PER_STG : NBLK;

        logic [WIDTH-1:0] x, y, s_in, s_nx;
        logic             c_in, c_nx, ovf_nx;
        logic [BLOCK:0]   rs;

        // Stage boundary: stage 0 takes the preprocessed operands, later stages the previous register.
        if (s == 0) begin : g_src
            assign x    = a;
            assign y    = b_eff;
            assign s_in = '0;
            assign c_in = c0;
        end else begin : g_src
            assign x    = a_p[s-1];
            assign y    = b_p[s-1];
            assign s_in = sum_p[s-1];
            assign c_in = c_p[s-1];
        end

        always_comb begin
            s_nx   = s_in;
            c_nx   = c_in;
            ovf_nx = 1'b0;
            rs     = '0;
            for (int k = LO; k < HI; k++) begin
                if (k == 0) begin
                    rs = rip(x[k*BLOCK +: BLOCK], y[k*BLOCK +: BLOCK], c_nx);
                end else begin
                    // Both carry hypotheses are evaluated; the incoming carry only picks one.
                    rs = c_nx ? rip(x[k*BLOCK +: BLOCK], y[k*BLOCK +: BLOCK], 1'b1)
                              : rip(x[k*BLOCK +: BLOCK], y[k*BLOCK +: BLOCK], 1'b0);
                end
                s_nx[k*BLOCK +: BLOCK] = rs[BLOCK-1:0];
                if (k == NBLK - 1) begin
                    ovf_nx = (x[WIDTH-1] ^ y[WIDTH-1] ^ rs[BLOCK-1]) ^ rs[BLOCK];
                end
                c_nx = rs[BLOCK];
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                a_p[s]   <= x;
                b_p[s]   <= y;
                sum_p[s] <= s_nx;
                c_p[s]   <= c_nx;
                ovf_p[s] <= ovf_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) vld_p[s] <= 1'b0;
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
        end
    end

    // Output boundary: data registers are not reset, so results are gated by the valid bit.
    assign out_valid = vld_p[STAGES-1];
    assign sum       = out_valid ? sum_p[STAGES-1] : '0;
    assign cout      = out_valid && c_p[STAGES-1];
    assign ovf       = out_valid && ovf_p[STAGES-1];
    assign zero      = out_valid && (sum_p[STAGES-1] == '0);

endmodule

// File: tb/tb_csel_addsub_pipe.sv
// Bench for csel_addsub_pipe at WIDTH=16, BLOCK=4, BLK_PER_STG=2 (two stages).
// Results are predicted with plain integer arithmetic and matched in order through a queue.
module tb_csel_addsub_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    csel_addsub_pipe #(.WIDTH(W), .BLOCK(4), .BLK_PER_STG(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
    } res_t;

    res_t exp_q[$];
    res_t sb_e;
    int   n_chk = 0;
    int   n_err = 0;

    function automatic res_t model(input logic [W-1:0] pa, input logic [W-1:0] pb,
                                   input logic pc, input logic ps);
        res_t r;
        int   full;
        int   sres;
        if (!ps) begin
            full = int'(pa) + int'(pb) + int'(pc);
            sres = int'($signed(pa)) + int'($signed(pb)) + int'(pc);
            r.c  = (full > 65535);
        end else begin
            full = int'(pa) - int'(pb) - int'(pc);
            sres = int'($signed(pa)) - int'($signed(pb)) - int'(pc);
            r.c  = (full >= 0);
        end
        r.s = 16'(full);
        r.o = (sres > 32767) || (sres < -32768);
        r.z = (r.s == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic drive(input logic [W-1:0] pa, input logic [W-1:0] pb,
                         input logic pc, input logic ps);
        a        = pa;
        b        = pb;
        cin      = pc;
        sub      = ps;
        in_valid = 1'b1;
    endtask

    // In-order scoreboard: push on accept, pop and compare on each output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    sb_e = exp_q.pop_front();
                    chk("sb_sum", 32'(sum), 32'(sb_e.s));
                    chk("sb_cout", 32'(cout), 32'(sb_e.c));
                    chk("sb_ovf", 32'(ovf), 32'(sb_e.o));
                    chk("sb_zero", 32'(zero), 32'(sb_e.z));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    always @(posedge rst) exp_q.delete();

    task automatic directed(input string tag, input logic [W-1:0] pa, input logic [W-1:0] pb,
                            input logic pc, input logic ps, input logic [W-1:0] es,
                            input logic ec, input logic eo, input logic ez);
        @(posedge clk); #1;
        drive(pa, pb, pc, ps);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
    endtask

    logic [W-1:0] bpa [4];
    logic [W-1:0] bpb [4];
    res_t         e0;
    logic         acc;
    int           bi;
    int           acc_n;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        directed("add_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("add_ovf",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("sub_zero",  16'h0010, 16'h000F, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: four beats offered against a stalled consumer.
        bpa = '{16'h1234, 16'hF00F, 16'h0F0F, 16'h7FFF};
        bpb = '{16'h4321, 16'h0FF1, 16'hF0F1, 16'h0001};
        e0  = model(bpa[0], bpb[0], 1'b0, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        bi = 0;
        drive(bpa[0], bpb[0], 1'b0, 1'b0);
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("bp_hold_sum", 32'(sum), 32'(e0.s));
                chk("bp_hold_cout", 32'(cout), 32'(e0.c));
            end
            @(posedge clk); #1;
            if (acc) begin
                bi++;
                if (bi < 4) drive(bpa[bi], bpb[bi], 1'b0, 1'b0);
                else in_valid = 1'b0;
            end
        end
        chk("bp_accepted", 32'(bi), 32'd2);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (bi == 4 && exp_q.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
            if (acc) begin
                bi++;
                if (bi < 4) drive(bpa[bi], bpb[bi], 1'b0, 1'b0);
                else in_valid = 1'b0;
            end
        end
        chk("bp_all_accepted", 32'(bi), 32'd4);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Random streaming with random consumer stalls.
        acc_n = 0;
        @(posedge clk); #1;
        drive(rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int cyc = 0; cyc < 8000 && acc_n < 1000; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) acc_n++;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                if (acc_n < 1000 && $urandom_range(0, 4) != 0)
                    drive(rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else
                    in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 32'(acc_n), 32'd1000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        chk("stream_idle", 32'(out_valid), 32'd0);

        // Reset with two beats in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(16'h9000, 16'h9000, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(16'h2222, 16'h0001, 1'b1, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        chk("rst_pre_vld", 32'(out_valid), 32'd1);
        chk("rst_pre_sum", 32'(sum), 32'h2000);
        chk("rst_pre_ovf", 32'(ovf), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_vld", 32'(out_valid), 32'd0);
        chk("rst_mid_sum", 32'(sum), 32'd0);
        chk("rst_mid_cout", 32'(cout), 32'd0);
        chk("rst_mid_ovf", 32'(ovf), 32'd0);
        chk("rst_mid_zero", 32'(zero), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end
        directed("post_rst", 16'h0042, 16'h0018, 1'b0, 1'b1, 16'h002A, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
